// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and single-outstanding instruction fetch with redirect squash.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fetch_misaligned.
module fetch_pc_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                   fetch_misaligned,
`endif
    input  logic                   instr_ready
);
`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
`endif
    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   drop_q, drop_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   redir;
    logic [ADDR_WIDTH-1:0]  tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                   misaligned_q, misaligned_d;
    logic                   bad;
    assign redir = redirect_valid && state_q != IDLE && state_q != HALT;
    assign tgt = redirect_pc;
    assign bad = redir && |redirect_pc[1:0];
`else
    assign redir = redirect_valid && state_q != IDLE;
    assign tgt = redirect_pc & ~ADDR_WIDTH'(3);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                state_d = imem_req_ready ? WAIT : REQ;
                if (redir) begin
                    pc_d   = tgt;
                    drop_d = imem_req_ready;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redir) begin
                        state_d = REQ;
                    end else begin
                        state_d       = OUT;
                        instr_d       = imem_resp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end
                end
                // A redirect with no response yet leaves the old request outstanding; drop its data later
                if (redir) begin
                    pc_d   = tgt;
                    drop_d = drop_d || !imem_resp_valid;
                end
            end
            OUT: begin
                if (redir || instr_ready) begin
                    pc_d          = redir ? tgt : pc_q + ADDR_WIDTH'(4);
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = state_q;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q;
        if (bad) begin
            pc_d          = pc_q;
            instr_valid_d = 1'b0;
            misaligned_d  = 1'b1;
            state_d       = HALT;
        end
`endif
    end
    always_comb begin
        imem_req_valid   = state_q == REQ;
        imem_req_addr    = pc_q;
        instr_valid      = instr_valid_q;
        instr            = instr_q;
        instr_pc         = instr_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fetch_misaligned = misaligned_q;
`endif
    end
endmodule
